// File: rtl/muldiv_seq_pkg.sv
// Shared op codes and FSM states for the multiply/divide sequencer.
// The control decoder and hazard unit import the same encodings.
package muldiv_seq_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } md_state_e;

  // Signed ops latch operand magnitudes and fix the signs up at the end
  function automatic logic md_is_signed(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the sequencer datapath: a shift-add multiply step
// or a restoring compare-subtract-shift divide step on {hi_part, lo_part}.
module muldiv_step
  import muldiv_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_out
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             ge;

  // Multiply keeps the multiplier in the low half and shifts the product in from the top;
  // divide shifts the dividend out of the low half into the remainder.
  always_comb begin
    sum     = '0;
    rem_sh  = '0;
    diff    = '0;
    ge      = 1'b0;
    acc_out = acc_in;
    if (is_div) begin
      rem_sh = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-1]};
      ge     = rem_sh >= {1'b0, operand};
      diff   = rem_sh[WIDTH-1:0] - operand;
      if (ge)
        acc_out = {diff, acc_in[WIDTH-2:0], 1'b1};
      else
        acc_out = {rem_sh[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
    end else begin
      sum     = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, operand} : '0);
      acc_out = {sum, acc_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO, with MTHI/MTLO writes
// and a start/busy/done handshake toward the EX stage.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  md_state_e          state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   operand;
  logic               sign_a;
  logic               sign_b;
  logic               div_op;

  logic [2*WIDTH-1:0] step_out;
  logic               op_signed;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (div_op),
    .acc_in  (acc),
    .operand (operand),
    .acc_out (step_out)
  );

  // The most negative value negates to itself, which is its correct unsigned magnitude
  assign op_signed = md_is_signed(op);
  assign a_mag     = (op_signed && A[WIDTH-1]) ? -A : A;
  assign b_mag     = (op_signed && B[WIDTH-1]) ? -B : B;

  assign prod = (sign_a ^ sign_b) ? -acc : acc;
  assign quot = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem  = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      acc     <= '0;
      operand <= '0;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      div_op  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            case (op)
              MD_MTHI: hi <= A;
              MD_MTLO: lo <= A;
              MD_MULT, MD_MULTU: begin
                acc     <= {{WIDTH{1'b0}}, b_mag};
                operand <= a_mag;
                sign_a  <= op_signed & A[WIDTH-1];
                sign_b  <= op_signed & B[WIDTH-1];
                div_op  <= 1'b0;
                cnt     <= '0;
                busy    <= 1'b1;
                state   <= ST_MUL;
              end
              MD_DIV, MD_DIVU: begin
                acc     <= {{WIDTH{1'b0}}, a_mag};
                operand <= b_mag;
                sign_a  <= op_signed & A[WIDTH-1];
                sign_b  <= op_signed & B[WIDTH-1];
                div_op  <= 1'b1;
                cnt     <= '0;
                busy    <= 1'b1;
                state   <= ST_DIV;
              end
              default: ;
            endcase
          end
        end
        ST_MUL, ST_DIV: begin
          acc <= step_out;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1))
            state <= ST_FIX;
        end
        ST_FIX: begin
          if (div_op) begin
            hi <= rem;
            lo <= quot;
          end else begin
            hi <= prod[2*WIDTH-1:WIDTH];
            lo <= prod[WIDTH-1:0];
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed testbench for muldiv_seq: hand-computed multiply/divide results,
// MTHI/MTLO, flush, asynchronous reset and back-to-back issue.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests;
  int fails;
  int cyc;
  int done_seen;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives start for one edge; returns at the negedge after the issuing edge
  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    start = 1'b0;
    op    = MD_MULT;
    A     = '0;
    B     = '0;
    flush = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("reset_busy", {31'b0, busy}, 32'd0);
    checkOutput("reset_done", {31'b0, done}, 32'd0);
    checkOutput("reset_hi", hi, 32'd0);
    checkOutput("reset_lo", lo, 32'd0);
    rst_n = 1'b1;

    applyStimulus(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    waitDone(cyc);
    checkOutput("multu_busy_cycles", cyc, 32'd33);
    checkOutput("multu_done", {31'b0, done}, 32'd1);
    checkOutput("multu_hi", hi, 32'hFFFFFFFE);
    checkOutput("multu_lo", lo, 32'h00000001);
    @(negedge clk);
    checkOutput("multu_done_pulse", {31'b0, done}, 32'd0);

    applyStimulus(MD_MULT, 32'hFFFFFFF9, 32'd3);
    waitDone(cyc);
    checkOutput("mult_neg_done", {31'b0, done}, 32'd1);
    checkOutput("mult_neg_hi", hi, 32'hFFFFFFFF);
    checkOutput("mult_neg_lo", lo, 32'hFFFFFFEB);

    applyStimulus(MD_DIV, 32'hFFFFFFF9, 32'd2);
    waitDone(cyc);
    checkOutput("div_neg_lo", lo, 32'hFFFFFFFD);
    checkOutput("div_neg_hi", hi, 32'hFFFFFFFF);

    applyStimulus(MD_DIVU, 32'd100, 32'd0);
    waitDone(cyc);
    checkOutput("divu_zero_lo", lo, 32'hFFFFFFFF);
    checkOutput("divu_zero_hi", hi, 32'd100);

    applyStimulus(MD_DIV, 32'hFFFFFFF9, 32'd0);
    waitDone(cyc);
    checkOutput("div_zero_neg_lo", lo, 32'h00000001);
    checkOutput("div_zero_neg_hi", hi, 32'hFFFFFFF9);

    applyStimulus(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
    waitDone(cyc);
    checkOutput("div_ovf_lo", lo, 32'h80000000);
    checkOutput("div_ovf_hi", hi, 32'h00000000);

    applyStimulus(MD_DIVU, 32'd50, 32'd7);
    waitDone(cyc);
    checkOutput("divu_lo", lo, 32'd7);
    checkOutput("divu_hi", hi, 32'd1);

    @(negedge clk);
    start = 1'b1;
    op    = MD_MTHI;
    A     = 32'h12345678;
    @(negedge clk);
    checkOutput("mthi_hi", hi, 32'h12345678);
    checkOutput("mthi_busy", {31'b0, busy}, 32'd0);
    checkOutput("mthi_done", {31'b0, done}, 32'd0);
    op = MD_MTLO;
    A  = 32'h9ABCDEF0;
    @(negedge clk);
    start = 1'b0;
    checkOutput("mtlo_lo", lo, 32'h9ABCDEF0);
    checkOutput("mtlo_hi_kept", hi, 32'h12345678);
    checkOutput("mtlo_busy", {31'b0, busy}, 32'd0);
    checkOutput("mtlo_done", {31'b0, done}, 32'd0);

    @(negedge clk);
    start = 1'b1;
    op    = MD_MTHI;
    A     = 32'h5A5A5A5A;
    @(negedge clk);
    op = MD_MTLO;
    @(negedge clk);
    start = 1'b0;
    applyStimulus(MD_DIVU, 32'd50, 32'd7);
    start = 1'b1;
    op    = MD_MULTU;
    A     = 32'd3;
    B     = 32'd3;
    repeat (9) @(negedge clk);
    checkOutput("flush_pre_busy", {31'b0, busy}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    checkOutput("flush_busy", {31'b0, busy}, 32'd0);
    checkOutput("flush_done", {31'b0, done}, 32'd0);
    checkOutput("flush_hi", hi, 32'h5A5A5A5A);
    checkOutput("flush_lo", lo, 32'h5A5A5A5A);
    flush = 1'b0;
    start = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    checkOutput("flush_no_activity", done_seen, 32'd0);
    checkOutput("flush_lo_kept", lo, 32'h5A5A5A5A);

    applyStimulus(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (19) @(negedge clk);
    checkOutput("rst_pre_busy", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_async_hi", hi, 32'd0);
    checkOutput("rst_async_lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(MD_MULTU, 32'd2, 32'd3);
    start = 1'b1;
    op    = MD_MULTU;
    A     = 32'd4;
    B     = 32'd5;
    waitDone(cyc);
    checkOutput("b2b_first_cycles", cyc, 32'd33);
    checkOutput("b2b_first_done", {31'b0, done}, 32'd1);
    checkOutput("b2b_first_hi", hi, 32'd0);
    checkOutput("b2b_first_lo", lo, 32'd6);
    @(negedge clk);
    start = 1'b0;
    checkOutput("b2b_second_busy", {31'b0, busy}, 32'd1);
    checkOutput("b2b_second_lo_hold", lo, 32'd6);
    waitDone(cyc);
    checkOutput("b2b_second_cycles", cyc, 32'd33);
    checkOutput("b2b_second_hi", hi, 32'd0);
    checkOutput("b2b_second_lo", lo, 32'd20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
